// File: rtl/echo_mixer.sv
// echo_mixer: mixes a dry sample stream with an attenuated wet (delayed) stream.
// The first dry word of each session is a config word: it latches i_atten and
// produces no output. Later dry words go through a two-stage pipeline. Stage 1
// registers the dry sample and the shifted wet term. Stage 2 forms a saturating
// sum. There is no backpressure, so one sample can be accepted every cycle.
// Optional feature: define ECHO_MIXER_SAT_CNT_EN to add the o_sat_count
// saturation event counter.
module echo_mixer #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ATTEN_WIDTH = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_dry_valid,
    input  logic [DATA_WIDTH-1:0]  i_dry_data,
    input  logic                   i_wet_valid,
    input  logic [DATA_WIDTH-1:0]  i_wet_data,
    input  logic [ATTEN_WIDTH-1:0] i_atten,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
`ifdef ECHO_MIXER_SAT_CNT_EN
    output logic                   o_cfg_done,
    output logic [15:0]            o_sat_count
`else
    output logic                   o_cfg_done
`endif
);

    localparam logic [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SatMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {StWaitCfg, StRun} state_e;

    state_e                 state_q;
    logic [ATTEN_WIDTH-1:0] atten_q;

    logic                   accept;
    logic [DATA_WIDTH-1:0]  wet_term;

    logic                   s1_valid_q;
    logic [DATA_WIDTH-1:0]  s1_dry_q;
    logic [DATA_WIDTH-1:0]  s1_wet_q;

    logic [DATA_WIDTH:0]    sum;
    logic                   overflow;
    logic [DATA_WIDTH-1:0]  sat_data;

    // Session FSM: the config word latches the attenuation; cfg_done is registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StWaitCfg;
            atten_q    <= '0;
            o_cfg_done <= 1'b0;
        end else begin
            unique case (state_q)
                StWaitCfg: begin
                    if (i_dry_valid) begin
                        atten_q    <= i_atten;
                        state_q    <= StRun;
                        o_cfg_done <= 1'b1;
                    end
                end
                StRun: begin
                    o_cfg_done <= 1'b1;
                end
            endcase
        end
    end

    // Stage-1 inputs: accept only run-state dry words; the wet term is an arithmetic shift
    always_comb begin
        accept   = (state_q == StRun) && i_dry_valid;
        wet_term = '0;
        if (i_wet_valid) begin
            // Shifts of DATA_WIDTH or more leave only the sign bits (0 or -1).
            wet_term = $signed(i_wet_data) >>> atten_q;
        end
    end

    // Stage 1: register the dry sample and the wet term
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_dry_q   <= '0;
            s1_wet_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_dry_q <= i_dry_data;
                s1_wet_q <= wet_term;
            end
        end
    end

    // Stage-2 arithmetic: widen by one bit, then clamp to the signed output range
    always_comb begin
        sum      = {s1_dry_q[DATA_WIDTH-1], s1_dry_q} + {s1_wet_q[DATA_WIDTH-1], s1_wet_q};
        overflow = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
        sat_data = sum[DATA_WIDTH-1:0];
        if (overflow) begin
            sat_data = sum[DATA_WIDTH] ? SatMin : SatMax;
        end
    end

    // Stage 2: output register; data holds while no valid sample arrives
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= s1_valid_q;
            if (s1_valid_q) begin
                o_data <= sat_data;
            end
        end
    end

`ifdef ECHO_MIXER_SAT_CNT_EN
    // Saturation event counter; it stops at all-ones
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sat_count <= '0;
        end else if (s1_valid_q && overflow && (o_sat_count != 16'hFFFF)) begin
            o_sat_count <= o_sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_echo_mixer.sv
// tb_echo_mixer: directed corner cases followed by randomized traffic. Every
// output is checked each cycle against a session-level reference model that
// uses plain integer arithmetic (floor-divide for the shift, clamp for saturation).
module tb_echo_mixer;

    logic        i_clk;
    logic        i_rst;
    logic        i_dry_valid;
    logic [31:0] i_dry_data;
    logic        i_wet_valid;
    logic [31:0] i_wet_data;
    logic [4:0]  i_atten;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_cfg_done;
`ifdef ECHO_MIXER_SAT_CNT_EN
    logic [15:0] o_sat_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_cfg;
    int unsigned m_atten;
    bit          m_pend_v;
    logic [31:0] m_pend_d;
    bit          m_pend_sat;
    bit          exp_v;
    logic [31:0] exp_d;
    int unsigned exp_sat;

    echo_mixer #(
        .DATA_WIDTH (32),
        .ATTEN_WIDTH(5)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_dry_valid(i_dry_valid),
        .i_dry_data (i_dry_data),
        .i_wet_valid(i_wet_valid),
        .i_wet_data (i_wet_data),
        .i_atten    (i_atten),
        .o_valid    (o_valid),
        .o_data     (o_data),
`ifdef ECHO_MIXER_SAT_CNT_EN
        .o_cfg_done (o_cfg_done),
        .o_sat_count(o_sat_count)
`else
        .o_cfg_done (o_cfg_done)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Arithmetic right shift expressed as floor division by 2^sh
    function automatic longint floor_shift(input longint x, input int unsigned sh);
        longint p;
        p = 64'sd1 <<< sh;
        if (x >= 0) return x / p;
        return -((-x + p - 1) / p);
    endfunction

    // Drive one cycle, advance the model, compare every output
    task automatic step(input logic rst, input logic dv, input logic [31:0] dd,
                        input logic wv, input logic [31:0] wd, input logic [4:0] at);
        longint s;
        longint w;
        i_rst       = rst;
        i_dry_valid = dv;
        i_dry_data  = dd;
        i_wet_valid = wv;
        i_wet_data  = wd;
        i_atten     = at;
        @(posedge i_clk);
        #1;
        if (rst) begin
            m_cfg    = 1'b0;
            m_atten  = 0;
            m_pend_v = 1'b0;
            exp_v    = 1'b0;
            exp_d    = '0;
            exp_sat  = 0;
        end else begin
            exp_v = m_pend_v;
            if (m_pend_v) begin
                exp_d = m_pend_d;
                if (m_pend_sat && exp_sat < 65535) exp_sat++;
            end
            m_pend_v = 1'b0;
            if (dv && m_cfg) begin
                w = wv ? floor_shift(longint'($signed(wd)), m_atten) : 0;
                s = longint'($signed(dd)) + w;
                m_pend_sat = 1'b0;
                if (s > 64'sd2147483647) begin
                    s = 64'sd2147483647;
                    m_pend_sat = 1'b1;
                end else if (s < -64'sd2147483648) begin
                    s = -64'sd2147483648;
                    m_pend_sat = 1'b1;
                end
                m_pend_v = 1'b1;
                m_pend_d = s[31:0];
            end else if (dv) begin
                m_cfg   = 1'b1;
                m_atten = int'(at);
            end
        end
        check_eq("o_valid", {63'd0, o_valid}, {63'd0, exp_v});
        check_eq("o_data", {32'd0, o_data}, {32'd0, exp_d});
        check_eq("o_cfg_done", {63'd0, o_cfg_done}, {63'd0, m_cfg});
`ifdef ECHO_MIXER_SAT_CNT_EN
        check_eq("o_sat_count", {48'd0, o_sat_count}, 64'(exp_sat));
`endif
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: v = 32'h7FFF_FF00 | (v & 32'hFF);
            1: v = 32'h8000_0000 | (v & 32'hFF);
            2: v = (v & 32'h3FF) - 32'd512;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        m_cfg = 0; m_atten = 0; m_pend_v = 0; m_pend_d = '0; m_pend_sat = 0;
        exp_v = 0; exp_d = '0; exp_sat = 0;

        // Reset state
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 32'd9, 1'b1, 32'd9, 5'd3);

        // Config word: no output, cfg_done next cycle
        step(1'b0, 1'b1, 32'h5, 1'b0, '0, 5'd1);
        // 100 + (200 >>> 1) = 200
        step(1'b0, 1'b1, 32'd100, 1'b1, 32'd200, 5'd7);
        idle(2);

        // Positive saturation with atten 0
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h0, 1'b0, '0, 5'd0);
        step(1'b0, 1'b1, 32'h7FFF_FFF0, 1'b1, 32'h40, 5'd0);
        idle(2);

        // -10 with no wet; 0 + (-7 >>> 1) = -4
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h0, 1'b0, '0, 5'd1);
        step(1'b0, 1'b1, -32'sd10, 1'b0, '0, 5'd0);
        step(1'b0, 1'b1, 32'd0, 1'b1, -32'sd7, 5'd0);
        idle(2);

        // Wet without dry is dropped
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1, 32'd1234, '0);

        // Eight back-to-back words with reset on the fourth
        for (int k = 0; k < 8; k++) begin
            step((k == 3), 1'b1, 32'd1000 + k, 1'b1, 32'd50, 5'd2);
        end
        idle(3);

        // Full-range shift: attenuation 31
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h0, 1'b0, '0, 5'd31);
        step(1'b0, 1'b1, 32'd20, 1'b1, 32'h8000_0001, '0);
        step(1'b0, 1'b1, 32'd20, 1'b1, 32'h7FFF_FFFF, '0);
        // Negative saturation
        step(1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0000, '0);
        idle(2);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), pick_val(),
                 $urandom_range(0, 1) == 1, pick_val(), 5'($urandom));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
